// File: rtl/dma_pkg.sv
// Shared types for the DMA descriptor queue: descriptor payload and sequencer states.
package dma_pkg;

   localparam int unsigned DMA_ADDR_W = 8;
   localparam int unsigned DMA_SIZE_W = 8;

   typedef struct packed {
      logic [DMA_ADDR_W-1:0] src;
      logic [DMA_ADDR_W-1:0] dst;
      logic [DMA_SIZE_W-1:0] size;
   } dma_cmd_t;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT
   } dma_q_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// Descriptor FIFO: synchronous write, registered pointers/flags, head shown combinationally.
module cmd_fifo
   import dma_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  dma_cmd_t                 wdata,
   input  logic                     pop,
   output dma_cmd_t                 rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   dma_cmd_t        mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic            full_q, full_d;
   logic            empty_q, empty_d;
   logic            wr_en;
   logic            rd_en;

   // Full is judged on the current occupancy, so a same-cycle pop never frees room for a push.
   always_comb begin
      wr_en    = push && !full_q;
      rd_en    = pop && !empty_q;
      wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(wr_en) - CW'(rd_en);
      full_d   = (count_d == CW'(DEPTH));
      empty_d  = (count_d == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/dma_cmd_queue.sv
// Descriptor queue and sequencer: pops queued copy descriptors and launches the copier
// one at a time, waiting for each finished rise before starting the next.
module dma_cmd_queue
   import dma_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned SIZE_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [ADDR_W-1:0]        push_src,
   input  logic [ADDR_W-1:0]        push_dst,
   input  logic [SIZE_W-1:0]        push_size,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic [ADDR_W-1:0]        src_addr,
   output logic [ADDR_W-1:0]        dst_addr,
   output logic [SIZE_W-1:0]        copy_size,
   output logic                     start,
   input  logic                     finished,
   output logic                     busy,
   output logic                     done,
   output logic [7:0]               done_cnt
);

   dma_cmd_t            wdata;
   dma_cmd_t            head;
   logic                fifo_full;
   logic                fifo_empty;
   logic                pop;

   dma_q_state_t        state_q, state_d;
   logic [ADDR_W-1:0]   src_q, src_d;
   logic [ADDR_W-1:0]   dst_q, dst_d;
   logic [SIZE_W-1:0]   size_q, size_d;
   logic                start_q, start_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [7:0]          done_cnt_q, done_cnt_d;
   logic                overflow_q, overflow_d;
   logic                finished_q, finished_d;

   always_comb begin
      wdata.src  = DMA_ADDR_W'(push_src);
      wdata.dst  = DMA_ADDR_W'(push_dst);
      wdata.size = DMA_SIZE_W'(push_size);
   end

   cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wdata),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (count)
   );

   // Sequencer next state; zero-length descriptors retire directly from IDLE without a launch.
   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      dst_d      = dst_q;
      size_d     = size_q;
      done_d     = 1'b0;
      done_cnt_d = done_cnt_q;
      pop        = 1'b0;
      overflow_d = overflow_q | (push & fifo_full);
      finished_d = finished;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (head.size != '0) begin
                  src_d   = ADDR_W'(head.src);
                  dst_d   = ADDR_W'(head.dst);
                  size_d  = SIZE_W'(head.size);
                  state_d = LAUNCH;
               end else begin
                  done_d     = 1'b1;
                  done_cnt_d = done_cnt_q + 8'd1;
               end
            end
         end
         LAUNCH: begin
            state_d = WAIT;
         end
         WAIT: begin
            // Only a fresh rise counts; a level held over from the last transfer is ignored.
            if (finished && !finished_q) begin
               done_d     = 1'b1;
               done_cnt_d = done_cnt_q + 8'd1;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      start_d = (state_d == LAUNCH);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         src_q      <= '0;
         dst_q      <= '0;
         size_q     <= '0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         done_cnt_q <= '0;
         overflow_q <= 1'b0;
         finished_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         size_q     <= size_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         done_cnt_q <= done_cnt_d;
         overflow_q <= overflow_d;
         finished_q <= finished_d;
      end
   end

   assign full      = fifo_full;
   assign overflow  = overflow_q;
   assign src_addr  = src_q;
   assign dst_addr  = dst_q;
   assign copy_size = size_q;
   assign start     = start_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign done_cnt  = done_cnt_q;

endmodule
